hazard_ctrl_seq: RTL and testbench

- Sequential successor to the 5-stage pipeline hazard detector.
- Handles multi-cycle load-use stalls, multi-cycle branch flushes and multi-cycle mul/div EX occupancy through one small FSM.
- Adds saturating stall/flush performance counters.
- Sits in the ID stage. Drives PC write enable, IF/ID stall/flush, the ID/EX control-zero mux, the ID/EX hold and the EX/MEM bubble.

---
 rtl/hazard_ctrl_seq_if.sv | 47 ++++
 rtl/hazard_ctrl_seq.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl_seq.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_seq_if.sv
// rtl/hazard_ctrl_seq_if.sv - pipeline <-> hazard controller signal bundle
//
// Purpose: groups the ID-stage hazard inputs and the pipeline control
//          outputs of hazard_ctrl_seq into one interface.
// Ports (modport view of the hazard controller = slave):
//   inputs : memread_idex_i, rd_idex_i, rs1_ifid_i, rs2_ifid_i,
//            use_rs2_ifid_i, branch_taken_i, md_start_i
//   outputs: pcwrite_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
//            idex_stall_o, exmem_bubble_o, busy_o, stall_cnt_o, flush_cnt_o
// The master modport is the pipeline side that drives the hazard inputs.

interface hazard_ctrl_seq_if #(
    parameter int AW     = 5,
    parameter int PERF_W = 16
);
    logic              memread_idex_i;
    logic [AW-1:0]     rd_idex_i;
    logic [AW-1:0]     rs1_ifid_i;
    logic [AW-1:0]     rs2_ifid_i;
    logic              use_rs2_ifid_i;
    logic              branch_taken_i;
    logic              md_start_i;

    logic              pcwrite_o;
    logic              ifid_stall_o;
    logic              ifid_flush_o;
    logic              idex_bubble_o;
    logic              idex_stall_o;
    logic              exmem_bubble_o;
    logic              busy_o;
    logic [PERF_W-1:0] stall_cnt_o;
    logic [PERF_W-1:0] flush_cnt_o;

    modport master (
        output memread_idex_i, rd_idex_i, rs1_ifid_i, rs2_ifid_i,
               use_rs2_ifid_i, branch_taken_i, md_start_i,
        input  pcwrite_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
               idex_stall_o, exmem_bubble_o, busy_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  memread_idex_i, rd_idex_i, rs1_ifid_i, rs2_ifid_i,
               use_rs2_ifid_i, branch_taken_i, md_start_i,
        output pcwrite_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
               idex_stall_o, exmem_bubble_o, busy_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl_seq.sv
// rtl/hazard_ctrl_seq.sv - multi-cycle load-use / branch / mul-div hazard controller
//
// Purpose: ID-stage hazard controller for a 5-stage pipeline. Handles
//          multi-cycle load-use stalls, multi-cycle branch flushes and
//          multi-cycle mul/div EX occupancy with one FSM, and keeps
//          saturating stall/flush performance counters.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   hz     - hazard_ctrl_seq_if.slave: hazard inputs, pipeline control
//            outputs (pcwrite/stall/flush/bubble), busy and perf counters
// Parameters: AW register-address width, MEM_STALL / FLUSH_CYC / MD_LAT
//   cycle lengths of each event (all >= 1), PERF_W counter width.
//   AW and PERF_W must match the connected interface.

module hazard_ctrl_seq #(
    parameter int AW        = 5,
    parameter int MEM_STALL = 1,
    parameter int FLUSH_CYC = 1,
    parameter int MD_LAT    = 4,
    parameter int PERF_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hazard_ctrl_seq_if.slave hz
);

    localparam int MAX_AB = (MEM_STALL > FLUSH_CYC) ? MEM_STALL : FLUSH_CYC;
    localparam int MAX_C  = (MAX_AB > MD_LAT) ? MAX_AB : MD_LAT;
    localparam int CW     = $clog2(MAX_C + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        FLUSH   = 2'd2,
        MD_BUSY = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    logic [AW-1:0]     rd;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic              lu;

    logic              pcwrite;
    logic              ifid_stall;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              idex_stall;
    logic              exmem_bubble;

    assign rd  = hz.rd_idex_i;
    assign rs1 = hz.rs1_ifid_i;
    assign rs2 = hz.rs2_ifid_i;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign lu = hz.memread_idex_i && (rd != '0) &&
                ((rd == rs1) || (hz.use_rs2_ifid_i && (rd == rs2)));

    // Control outputs are combinational so the first hazard cycle is
    // covered in IDLE; the FSM only extends events lasting more than one
    // cycle. Reset forces defaults regardless of inputs.
    always_comb begin
        pcwrite      = 1'b1;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        idex_stall   = 1'b0;
        exmem_bubble = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    // Load-use wins so a branch depending on load data is
                    // not resolved with stale operands.
                    if (lu) begin
                        pcwrite     = 1'b0;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (hz.branch_taken_i) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                LD_WAIT: begin
                    pcwrite     = 1'b0;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                MD_BUSY: begin
                    // IF, ID and ID/EX are frozen; the mul/div result is
                    // still forming, so EX/MEM receives bubbles.
                    pcwrite      = 1'b0;
                    ifid_stall   = 1'b1;
                    idex_stall   = 1'b1;
                    exmem_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Mul/div occupancy overrides load/flush extension:
                    // the ID instruction is re-evaluated once EX frees up.
                    if (hz.md_start_i && (MD_LAT > 1)) begin
                        state <= MD_BUSY;
                        cnt   <= CW'(MD_LAT - 1);
                    end else if (lu && (MEM_STALL > 1)) begin
                        state <= LD_WAIT;
                        cnt   <= CW'(MEM_STALL - 1);
                    end else if (!lu && hz.branch_taken_i && (FLUSH_CYC > 1)) begin
                        state <= FLUSH;
                        cnt   <= CW'(FLUSH_CYC - 1);
                    end
                end
                LD_WAIT, FLUSH, MD_BUSY: begin
                    // Inputs (including a stray md_start_i) are ignored here.
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            // Saturating counters: hold at all-ones instead of wrapping.
            if (!pcwrite && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + PERF_W'(1);
            end
        end
    end

    assign hz.pcwrite_o      = pcwrite;
    assign hz.ifid_stall_o   = ifid_stall;
    assign hz.ifid_flush_o   = ifid_flush;
    assign hz.idex_bubble_o  = idex_bubble;
    assign hz.idex_stall_o   = idex_stall;
    assign hz.exmem_bubble_o = exmem_bubble;
    assign hz.busy_o         = (state != IDLE);
    assign hz.stall_cnt_o    = stall_cnt;
    assign hz.flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// tb/tb_hazard_ctrl_seq.sv - self-checking bench for hazard_ctrl_seq

module tb_hazard_ctrl_seq;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    // dut_a: all event lengths 1 (legacy single-cycle behaviour).
    // dut_b: MEM_STALL=2, FLUSH_CYC=3, MD_LAT=4, 4-bit counters.
    hazard_ctrl_seq_if #(.AW(5), .PERF_W(16)) if_a ();
    hazard_ctrl_seq_if #(.AW(5), .PERF_W(4))  if_b ();

    hazard_ctrl_seq #(
        .AW(5), .MEM_STALL(1), .FLUSH_CYC(1), .MD_LAT(1), .PERF_W(16)
    ) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (if_a.slave)
    );

    hazard_ctrl_seq #(
        .AW(5), .MEM_STALL(2), .FLUSH_CYC(3), .MD_LAT(4), .PERF_W(4)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (if_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // md_start_i must only be raised while the controller is idle.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(if_b.busy_o && if_b.md_start_i))
                else $error("protocol: md_start_i while busy");
        end
    end

    typedef struct {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use2;
        logic       br;
        logic       md;
        logic [6:0] exp; // {pc, ifid_stall, flush, idex_bubble, idex_stall, exmem_bubble, busy}
    } vec_t;

    vec_t vecs[11];

    function automatic logic [6:0] ob_a();
        return {if_a.pcwrite_o, if_a.ifid_stall_o, if_a.ifid_flush_o, if_a.idex_bubble_o,
                if_a.idex_stall_o, if_a.exmem_bubble_o, if_a.busy_o};
    endfunction

    function automatic logic [6:0] ob_b();
        return {if_b.pcwrite_o, if_b.ifid_stall_o, if_b.ifid_flush_o, if_b.idex_bubble_o,
                if_b.idex_stall_o, if_b.exmem_bubble_o, if_b.busy_o};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic set_a(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic use2, input logic br, input logic md);
        if_a.memread_idex_i = mr;
        if_a.rd_idex_i      = rd;
        if_a.rs1_ifid_i     = rs1;
        if_a.rs2_ifid_i     = rs2;
        if_a.use_rs2_ifid_i = use2;
        if_a.branch_taken_i = br;
        if_a.md_start_i     = md;
    endtask

    task automatic set_b(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic use2, input logic br, input logic md);
        if_b.memread_idex_i = mr;
        if_b.rd_idex_i      = rd;
        if_b.rs1_ifid_i     = rs1;
        if_b.rs2_ifid_i     = rs2;
        if_b.use_rs2_ifid_i = use2;
        if_b.branch_taken_i = br;
        if_b.md_start_i     = md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Called just after a rising edge; reset lasts well inside the cycle.
    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int exp_st;
        int exp_fl;
        passed = 0;
        total  = 0;

        vecs[0]  = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 7'b1000000};
        vecs[1]  = '{1'b1, 5'd5,  5'd5, 5'd0,  1'b0, 1'b0, 1'b0, 7'b0101000};
        vecs[2]  = '{1'b1, 5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 7'b1000000};
        vecs[3]  = '{1'b1, 5'd7,  5'd1, 5'd7,  1'b0, 1'b0, 1'b0, 7'b1000000};
        vecs[4]  = '{1'b1, 5'd7,  5'd1, 5'd7,  1'b1, 1'b0, 1'b0, 7'b0101000};
        vecs[5]  = '{1'b0, 5'd5,  5'd5, 5'd5,  1'b1, 1'b0, 1'b0, 7'b1000000};
        vecs[6]  = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b0, 7'b1011000};
        vecs[7]  = '{1'b1, 5'd9,  5'd9, 5'd0,  1'b0, 1'b1, 1'b0, 7'b0101000};
        vecs[8]  = '{1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 7'b1000000};
        vecs[9]  = '{1'b1, 5'd3,  5'd3, 5'd0,  1'b0, 1'b0, 1'b1, 7'b0101000};
        vecs[10] = '{1'b1, 5'd31, 5'd3, 5'd31, 1'b1, 1'b0, 1'b0, 7'b0101000};

        // Reset with a live hazard on dut_a: outputs must still be defaults.
        rst = 1'b1;
        set_a(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
        set_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        smp();
        chk("reset_a_outputs", ob_a(), 7'b1000000);
        chk("reset_b_outputs", ob_b(), 7'b1000000);
        chk("reset_a_stall_cnt", if_a.stall_cnt_o, 0);
        chk("reset_b_flush_cnt", if_b.flush_cnt_o, 0);
        tick();
        rst = 1'b0;

        // Table-driven legacy vectors on dut_a, one cycle each.
        exp_st = 0;
        exp_fl = 0;
        for (int i = 0; i < 11; i++) begin
            set_a(vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].use2, vecs[i].br, vecs[i].md);
            if (!vecs[i].exp[6]) exp_st++;
            if (vecs[i].exp[4])  exp_fl++;
            smp();
            chk($sformatf("vec%0d_outputs", i), ob_a(), vecs[i].exp);
            tick();
        end
        set_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        smp();
        chk("vec_stall_cnt", if_a.stall_cnt_o, exp_st);
        chk("vec_flush_cnt", if_a.flush_cnt_o, exp_fl);

        // Legacy: lu+branch stalls only, branch alone next cycle flushes.
        tick();
        set_a(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0);
        smp();
        chk("a_lu_br_stall", ob_a(), 7'b0101000);
        tick();
        set_a(1'b0, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0);
        smp();
        chk("a_br_after_lu", ob_a(), 7'b1011000);
        tick();
        set_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Seq A: 2-cycle load-use stall.
        pulse_reset();
        set_b(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        smp();
        chk("lu_c1", ob_b(), 7'b0101000);
        tick();
        set_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        smp();
        chk("lu_c2_ld_wait", ob_b(), 7'b0101001);
        tick();
        smp();
        chk("lu_c3_idle", ob_b(), 7'b1000000);
        chk("lu_stall_cnt", if_b.stall_cnt_o, 2);
        tick();

        // Seq B: lu+branch, branch held through LD_WAIT, then 3-cycle flush.
        pulse_reset();
        set_b(1'b1, 5'd6, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
        smp();
        chk("lubr_c1", ob_b(), 7'b0101000);
        tick();
        set_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        smp();
        chk("lubr_c2_ld_wait_ignores_br", ob_b(), 7'b0101001);
        tick();
        smp();
        chk("br_c3_flush_start", ob_b(), 7'b1011000);
        tick();
        set_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        smp();
        chk("br_c4_flush", ob_b(), 7'b1011001);
        tick();
        smp();
        chk("br_c5_flush", ob_b(), 7'b1011001);
        tick();
        smp();
        chk("br_c6_idle", ob_b(), 7'b1000000);
        chk("br_flush_cnt", if_b.flush_cnt_o, 3);
        chk("br_stall_cnt", if_b.stall_cnt_o, 2);
        tick();

        // Seq C: mul/div occupancy, hazards ignored while busy.
        pulse_reset();
        set_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        smp();
        chk("md_c1_default", ob_b(), 7'b1000000);
        tick();
        set_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        smp();
        chk("md_c2_busy", ob_b(), 7'b0100111);
        tick();
        set_b(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
        smp();
        chk("md_c3_ignores_lu_br", ob_b(), 7'b0100111);
        tick();
        set_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        smp();
        chk("md_c4_busy", ob_b(), 7'b0100111);
        tick();
        smp();
        chk("md_c5_idle", ob_b(), 7'b1000000);
        chk("md_stall_cnt", if_b.stall_cnt_o, 3);
        tick();
        set_b(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1);
        smp();
        chk("md_lu_c1", ob_b(), 7'b0101000);
        tick();
        set_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        smp();
        chk("md_lu_c2_md_wins", ob_b(), 7'b0100111);
        tick();
        tick();
        tick();
        smp();
        chk("md_lu_idle", ob_b(), 7'b1000000);
        tick();

        // Seq D: asynchronous reset mid MD_BUSY.
        pulse_reset();
        set_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        set_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        smp();
        chk("rst_pre_busy", ob_b(), 7'b0100111);
        chk("rst_pre_stall_cnt", if_b.stall_cnt_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", ob_b(), 7'b1000000);
        chk("rst_async_stall_cnt", if_b.stall_cnt_o, 0);
        #1;
        rst = 1'b0;
        tick();
        smp();
        chk("rst_after_idle", ob_b(), 7'b1000000);
        tick();

        // Seq E: 20 stall cycles saturate a 4-bit counter at 15.
        pulse_reset();
        set_b(1'b1, 5'd11, 5'd11, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (20) tick();
        set_b(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        smp();
        chk("sat_stall_cnt", if_b.stall_cnt_o, 15);
        chk("sat_flush_cnt", if_b.flush_cnt_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
